// File: rtl/ingress_frame_writer_pkg.sv
// ingress_frame_writer_pkg: shared widths, header/control field layout and FSM states
package ingress_frame_writer_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int PORT_NUB = 16;
  localparam int SEL_W = $clog2(PORT_NUB);
  localparam int PRIO_W = 3;
  localparam int CRC_W = 16;
  localparam int LEN_W = DATA_WIDTH - CRC_W - PRIO_W;
  localparam int HDR_W = SEL_W + PRIO_W + LEN_W;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {IDLE, RECV, DROP, CTRL, DRAIN} state_t;
  typedef struct packed {
    logic [SEL_W-1:0]  dest;
    logic [PRIO_W-1:0] prio;
    logic [LEN_W-1:0]  len;
  } hdr_t;
  function automatic logic [DATA_WIDTH-1:0] ctrl_word(logic [LEN_W-1:0] len, logic [CRC_W-1:0] crc, logic [PRIO_W-1:0] prio);
    return {len, crc, prio};
  endfunction
endpackage

// File: rtl/ingress_frame_writer_if.sv
// ingress_frame_writer_if: ingress beat handshake plus shared-cache write port
interface ingress_frame_writer_if;
  import ingress_frame_writer_pkg::*;
  logic                  wr_sop;
  logic                  wr_eop;
  logic                  wr_vld;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic [PORT_NUB-1:0]   cache_full;
  logic                  cache_wr_en;
  logic [SEL_W-1:0]      cache_wr_sel;
  logic                  cache_wr_sop;
  logic                  cache_wr_eop;
  logic [DATA_WIDTH-1:0] cache_wr_data;
  modport master (
    output wr_sop, wr_eop, wr_vld, wr_data, cache_full,
    input  wr_ready, cache_wr_en, cache_wr_sel, cache_wr_sop, cache_wr_eop, cache_wr_data
  );
  modport slave (
    input  wr_sop, wr_eop, wr_vld, wr_data, cache_full,
    output wr_ready, cache_wr_en, cache_wr_sel, cache_wr_sop, cache_wr_eop, cache_wr_data
  );
endinterface

// File: rtl/ingress_frame_writer_crc.sv
// ingress_frame_writer_crc: CRC-16 (poly 0x1021, zero init) over whole data words, MSB first
module ingress_frame_writer_crc
  import ingress_frame_writer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CRC_W-1:0]      crc
);
  logic [CRC_W-1:0] crc_q, crc_d, c;
  always_comb begin
    c = crc_q;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) c = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ data[i]) ? 16'h1021 : 16'h0000);
    crc_d = en ? c : crc_q;
  end
  always_ff @(posedge clk) begin
    crc_q <= !rst_n ? '0 : crc_d;
  end
  assign crc = crc_q;
endmodule

// File: rtl/ingress_frame_writer_fifo.sv
// ingress_frame_writer_fifo: single-clock first-word-fall-through FIFO with synchronous flush
module ingress_frame_writer_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && count_q != (AW+1)'(DEPTH);
    do_pop = pop && count_q != '0;
    wptr_d = flush ? '0 : wptr_q + AW'(do_push);
    rptr_d = flush ? '0 : rptr_q + AW'(do_pop);
    count_d = flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr_q] <= wdata;
  end
  assign rdata = mem[rptr_q];
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/ingress_frame_writer.sv
// ingress_frame_writer: store-and-forward ingress that validates a frame, CRCs its payload and writes it to a cache queue
module ingress_frame_writer
  import ingress_frame_writer_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ingress_frame_writer_if.slave bus,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);
  state_t state_q, state_d;
  logic [SEL_W-1:0] dest_q, dest_d;
  logic [PRIO_W-1:0] prio_q, prio_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, cnt_nx;
  logic [CNT_W-1:0] frame_q, frame_d, err_q, err_d;
  logic ready_q, ready_d;
  logic wen_q, wen_d, wsop_q, wsop_d, weop_q, weop_d;
  logic [SEL_W-1:0] wsel_q, wsel_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic xfer, full, err, push, pop, flush, crc_clr, crc_en, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [AW:0] fifo_count;
  logic [CRC_W-1:0] crc;
  hdr_t hdr;
  assign hdr = hdr_t'(bus.wr_data[HDR_W-1:0]);
  ingress_frame_writer_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .pop(pop),
    .wdata(bus.wr_data), .rdata(fifo_rdata), .empty(fifo_empty), .count(fifo_count)
  );
  ingress_frame_writer_crc u_crc (
    .clk(clk), .rst_n(rst_n & ~crc_clr), .en(crc_en), .data(bus.wr_data), .crc(crc)
  );
  always_comb begin
    state_d = state_q;
    dest_d = dest_q;
    prio_d = prio_q;
    len_d = len_q;
    cnt_d = cnt_q;
    frame_d = frame_q;
    err = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    flush = 1'b0;
    crc_clr = 1'b0;
    crc_en = 1'b0;
    wen_d = 1'b0;
    wsop_d = 1'b0;
    weop_d = 1'b0;
    wsel_d = '0;
    wdata_d = '0;
    xfer = bus.wr_vld && ready_q;
    full = bus.cache_full[dest_q];
    cnt_nx = cnt_q + 1'b1;
    case (state_q)
      IDLE: if (xfer) begin
        if (!bus.wr_sop) err = 1'b1;
        else begin
          dest_d = hdr.dest;
          prio_d = hdr.prio;
          len_d = hdr.len;
          cnt_d = '0;
          crc_clr = 1'b1;
          err = hdr.len == '0 || hdr.len > MAX_LEN || bus.wr_eop;
          state_d = !err ? RECV : bus.wr_eop ? IDLE : DROP;
        end
      end
      RECV: if (xfer) begin
        push = 1'b1;
        crc_en = 1'b1;
        cnt_d = cnt_nx;
        if (bus.wr_sop || (!bus.wr_eop && cnt_nx == len_q)) begin
          err = 1'b1;
          flush = 1'b1;
          state_d = DROP;
        end else if (bus.wr_eop) begin
          err = cnt_nx != len_q;
          flush = err;
          state_d = err ? IDLE : CTRL;
        end
      end
      DROP: state_d = xfer && bus.wr_eop ? IDLE : DROP;
      CTRL: if (!full) begin
        wen_d = 1'b1;
        wsop_d = 1'b1;
        wsel_d = dest_q;
        wdata_d = ctrl_word(len_q, crc, prio_q);
        state_d = DRAIN;
      end
      DRAIN: if (!fifo_empty && !full) begin
        pop = 1'b1;
        wen_d = 1'b1;
        wsel_d = dest_q;
        wdata_d = fifo_rdata;
        weop_d = fifo_count == (AW+1)'(1);
        frame_d = frame_q + CNT_W'(weop_d && frame_q != '1);
        state_d = weop_d ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_q + CNT_W'(err && err_q != '1);
    ready_d = state_d inside {IDLE, RECV, DROP};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dest_q <= '0;
      prio_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      frame_q <= '0;
      err_q <= '0;
      ready_q <= 1'b0;
      wen_q <= 1'b0;
      wsop_q <= 1'b0;
      weop_q <= 1'b0;
      wsel_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      dest_q <= dest_d;
      prio_q <= prio_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      frame_q <= frame_d;
      err_q <= err_d;
      ready_q <= ready_d;
      wen_q <= wen_d;
      wsop_q <= wsop_d;
      weop_q <= weop_d;
      wsel_q <= wsel_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.wr_ready = ready_q;
  assign bus.cache_wr_en = wen_q;
  assign bus.cache_wr_sel = wsel_q;
  assign bus.cache_wr_sop = wsop_q;
  assign bus.cache_wr_eop = weop_q;
  assign bus.cache_wr_data = wdata_q;
  assign frame_cnt = frame_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_ingress_frame_writer.sv
// tb_ingress_frame_writer: randomized frames against a frame-level model, scoreboarded cache writes
module tb_ingress_frame_writer;
  localparam int DEPTH = 256;
  localparam int GOOD = 0, SHORT = 1, LONG = 2, MIDSOP = 3, BADLEN = 4, STRAY = 5, HDREOP = 6;
  typedef struct packed {
    logic [3:0]  sel;
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] frame_cnt, err_cnt;
  int checks = 0, errors = 0;
  int exp_frames = 0, exp_errs = 0;
  wr_t exp_q[$];
  bit sb_on = 1'b1;
  bit random_full = 1'b0;
  logic [15:0] prev_full = '0;
  ingress_frame_writer_if bif();
  ingress_frame_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask
  function automatic wr_t observed();
    return {bif.cache_wr_sel, bif.cache_wr_sop, bif.cache_wr_eop, bif.cache_wr_data};
  endfunction
  // polynomial long division of the payload bitstream, augmented by 16 zero bits
  function automatic logic [15:0] crc_ref(logic [31:0] words[$]);
    logic [16:0] r;
    r = '0;
    foreach (words[k]) for (int b = 31; b >= 0; b--) begin
      r = {r[15:0], words[k][b]};
      if (r[16]) r = r ^ 17'h11021;
    end
    for (int b = 0; b < 16; b++) begin
      r = {r[15:0], 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction
  always @(posedge clk) begin
    #1;
    bif.cache_full = random_full ? 16'($urandom & $urandom) : 16'h0;
  end
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && sb_on) begin
      if (bif.cache_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %h expected no write", observed());
        end else begin
          e = exp_q.pop_front();
          check("cache_write", 64'(observed()), 64'(e));
        end
        check("write_while_full", 64'(prev_full[bif.cache_wr_sel]), 64'(0));
      end else check("idle_zero", 64'(observed()), 64'(0));
    end
    prev_full = bif.cache_full;
  end
  task automatic beat(bit sop, bit eop, logic [31:0] data);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      bif.wr_vld = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bif.wr_vld = 1'b1;
    bif.wr_sop = sop;
    bif.wr_eop = eop;
    bif.wr_data = data;
    while (!acc) begin
      @(negedge clk);
      acc = bif.wr_ready;
      @(posedge clk);
      #1;
      if (++n > 5000) timeout("beat_accept");
    end
    bif.wr_vld = 1'b0;
    bif.wr_sop = 1'b0;
    bif.wr_eop = 1'b0;
    bif.wr_data = '0;
  endtask
  task automatic send_frame(int kind, int len, logic [3:0] dest, logic [2:0] prio);
    logic [31:0] pl[$];
    logic [31:0] hdr;
    int n, j;
    hdr = {12'($urandom), dest, prio, 13'(len)};
    case (kind)
      GOOD: begin
        for (int i = 0; i < len; i++) pl.push_back($urandom);
        exp_q.push_back({dest, 1'b1, 1'b0, 13'(len), crc_ref(pl), prio});
        foreach (pl[i]) exp_q.push_back({dest, 1'b0, i == len - 1, pl[i]});
        exp_frames++;
        beat(1'b1, 1'b0, hdr);
        foreach (pl[i]) beat(1'b0, i == len - 1, pl[i]);
      end
      SHORT: begin
        n = $urandom_range(1, len - 1);
        exp_errs++;
        beat(1'b1, 1'b0, hdr);
        for (int i = 1; i <= n; i++) beat(1'b0, i == n, $urandom);
      end
      LONG: begin
        n = len + $urandom_range(1, 3);
        exp_errs++;
        beat(1'b1, 1'b0, hdr);
        for (int i = 1; i <= n; i++) beat(1'b0, i == n, $urandom);
      end
      MIDSOP: begin
        j = $urandom_range(1, len - 1);
        n = j + $urandom_range(1, 3);
        exp_errs++;
        beat(1'b1, 1'b0, hdr);
        for (int i = 1; i <= n; i++) beat(i == j, i == n, $urandom);
      end
      BADLEN: begin
        exp_errs++;
        if ($urandom_range(0, 1) == 0) beat(1'b1, 1'b1, hdr);
        else begin
          n = $urandom_range(1, 3);
          beat(1'b1, 1'b0, hdr);
          for (int i = 1; i <= n; i++) beat(1'b0, i == n, $urandom);
        end
      end
      STRAY: begin
        exp_errs++;
        beat(1'b0, 1'($urandom), $urandom);
      end
      default: begin
        exp_errs++;
        beat(1'b1, 1'b1, hdr);
      end
    endcase
  endtask
  task automatic settle(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 || bif.wr_ready !== 1'b1) begin
      @(posedge clk);
      #1;
      if (++n > 20000) timeout(name);
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
    check({name, "_err_cnt"}, 64'(err_cnt), 64'(exp_errs));
  endtask
  initial begin
    int kind, len, n;
    bif.wr_vld = 1'b0;
    bif.wr_sop = 1'b0;
    bif.wr_eop = 1'b0;
    bif.wr_data = '0;
    bif.cache_full = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({bif.wr_ready, observed(), frame_cnt, err_cnt}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(bif.wr_ready), 64'(1));
    send_frame(GOOD, 4, 4'd3, 3'd5);
    settle("basic");
    send_frame(SHORT, 4, 4'd1, 3'd2);
    send_frame(GOOD, 3, 4'd7, 3'd1);
    settle("short_then_good");
    send_frame(LONG, 2, 4'd2, 3'd0);
    send_frame(MIDSOP, 5, 4'd9, 3'd6);
    send_frame(BADLEN, 0, 4'd4, 3'd3);
    send_frame(BADLEN, DEPTH + 1, 4'd4, 3'd3);
    send_frame(STRAY, 1, 4'd0, 3'd0);
    send_frame(HDREOP, 3, 4'd5, 3'd4);
    settle("errors");
    send_frame(GOOD, DEPTH, 4'd15, 3'd7);
    send_frame(GOOD, 1, 4'd0, 3'd0);
    settle("len_bounds");
    random_full = 1'b1;
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 9);
      kind = kind <= 3 ? GOOD : kind - 3;
      len = $urandom_range(2, 16);
      if (kind == GOOD && $urandom_range(0, 19) == 0) len = $urandom_range(200, DEPTH);
      if (kind == BADLEN) len = $urandom_range(0, 1) == 0 ? 0 : $urandom_range(DEPTH + 1, 8191);
      send_frame(kind, len, 4'($urandom), 3'($urandom));
    end
    settle("random");
    random_full = 1'b0;
    sb_on = 1'b0;
    send_frame(GOOD, 4, 4'd3, 3'd5);
    n = 0;
    do begin
      @(negedge clk);
      if (++n > 2000) timeout("drain_word1");
    end while (!(bif.cache_wr_en && !bif.cache_wr_sop));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_drain_reset", 64'({bif.wr_ready, observed(), frame_cnt, err_cnt}), 64'(0));
    rst_n = 1'b1;
    exp_q.delete();
    exp_frames = 0;
    exp_errs = 0;
    sb_on = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", 64'(bif.wr_ready), 64'(1));
    check("counters_after_release", 64'({frame_cnt, err_cnt}), 64'(0));
    repeat (5) @(posedge clk);
    #1;
    send_frame(GOOD, 5, 4'd6, 3'd2);
    settle("after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
